// File: rtl/pattern_capture_if.sv
// SRAM write-side bus and capture status shared between pattern_capture and its SRAM owner.
interface pattern_capture_if;
    logic        capture_active;
    logic        capture_done;
    logic [18:0] sram_addr_pat_cap;
    logic [7:0]  sram_data_pat_cap;
    logic        sram_we_pat_cap;

    modport master (
        output capture_active,
        output capture_done,
        output sram_addr_pat_cap,
        output sram_data_pat_cap,
        output sram_we_pat_cap
    );

    modport slave (
        input capture_active,
        input capture_done,
        input sram_addr_pat_cap,
        input sram_data_pat_cap,
        input sram_we_pat_cap
    );
endinterface

// File: rtl/pattern_capture.sv
// GPIO pattern capture: samples 1/2/4/8 synchronized pins per tick, packs MSB-first, writes bytes to SRAM.
// Optional start trigger on a selected pin edge is enabled by defining PAT_CAP_TRIGGER_EN.
module pattern_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_enable_pat_cap,
    input  logic [23:0] cfg_end_address_pat_cap,
    input  logic [1:0]  cfg_num_gpio_sel_pat_cap,
    input  logic [2:0]  cfg_timestep_sel_pat_cap,
    input  logic [3:0]  cfg_stage1_count_sel_pat_cap,
    input  logic [2:0]  cfg_trig_sel_pat_cap,
    input  logic        cfg_trig_pol_pat_cap,
    input  logic [7:0]  gpio_pat_cap_in,
    pattern_capture_if.master sram
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  gpio_meta, gpio_sync, gpio_prev;
    logic        en_was_low;
    logic [3:0]  s1_cnt;
    logic [23:0] s2_cnt;
    logic [3:0]  slot_k;
    logic [7:0]  pack_q, pack_next;
    logic [18:0] addr_q;
    logic [7:0]  data_q;
    logic        we_q;

    logic        enable, en_rise, trig_hit, tick, s1_wrap, s2_wrap, end_hit, byte_full;
    logic [3:0]  s1_limit, n_pins, slot_last;
    logic [23:0] dec_limit;

    assign enable = cfg_enable_pat_cap;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would let the synchronizer collapse into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_meta  <= '0;
            gpio_sync  <= '0;
            gpio_prev  <= '0;
            en_was_low <= 1'b0;
        end else begin
            gpio_meta  <= gpio_pat_cap_in;
            gpio_sync  <= gpio_meta;
            gpio_prev  <= gpio_sync;
            en_was_low <= ~enable;
        end
    end

    // en_was_low resets to 0, so an enable already high at reset release is not an edge.
    assign en_rise = enable & en_was_low;

`ifdef PAT_CAP_TRIGGER_EN
    logic trig_now, trig_old;
    assign trig_now = gpio_sync[cfg_trig_sel_pat_cap];
    assign trig_old = gpio_prev[cfg_trig_sel_pat_cap];
    assign trig_hit = cfg_trig_pol_pat_cap ? (trig_now & ~trig_old) : (~trig_now & trig_old);
`else
    logic unused_trig;
    assign unused_trig = ^{cfg_trig_sel_pat_cap, cfg_trig_pol_pat_cap, gpio_prev};
    assign trig_hit    = 1'b1;
`endif

    logic unused_end;
    assign unused_end = ^cfg_end_address_pat_cap[23:19];

    // A 1x1 tick would be one clock; stretch the prescaler to 2 to honour the 2-clock floor.
    assign s1_limit = (cfg_stage1_count_sel_pat_cap >= 4'd2) ? cfg_stage1_count_sel_pat_cap :
                      (cfg_timestep_sel_pat_cap == 3'd0)      ? 4'd2 : 4'd1;

    always_comb begin
        case (cfg_timestep_sel_pat_cap)
            3'd0:    dec_limit = 24'd1;
            3'd1:    dec_limit = 24'd10;
            3'd2:    dec_limit = 24'd100;
            3'd3:    dec_limit = 24'd1000;
            3'd4:    dec_limit = 24'd10000;
            3'd5:    dec_limit = 24'd100000;
            3'd6:    dec_limit = 24'd1000000;
            default: dec_limit = 24'd10000000;
        endcase
    end

    assign s1_wrap   = (s1_cnt == s1_limit - 4'd1);
    assign s2_wrap   = (s2_cnt == dec_limit - 24'd1);
    assign tick      = (state_q == CAPTURE) && s1_wrap && s2_wrap;
    assign n_pins    = 4'd1 << cfg_num_gpio_sel_pat_cap;
    assign slot_last = 4'd8 - n_pins;
    assign byte_full = tick && (slot_k == slot_last);
    assign end_hit   = (addr_q == cfg_end_address_pat_cap[18:0]);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pack_next = pack_q;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n_pins))
                pack_next[3'(7 - int'(slot_k) - i)] = gpio_sync[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (en_rise) state_d = ARMED;
                ARMED:   if (trig_hit) state_d = CAPTURE;
                CAPTURE: if (we_q && end_hit) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cnt <= '0;
            s2_cnt <= '0;
            slot_k <= '0;
            pack_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else if (!enable || state_q != CAPTURE) begin
            // Counters and the partial byte restart on every CAPTURE entry; an abort discards them.
            s1_cnt <= '0;
            s2_cnt <= '0;
            slot_k <= '0;
            pack_q <= '0;
            we_q   <= 1'b0;
            if (!enable || state_q == IDLE) begin
                addr_q <= '0;
                data_q <= '0;
            end
        end else begin
            if (s1_wrap) begin
                s1_cnt <= '0;
                s2_cnt <= s2_wrap ? 24'd0 : s2_cnt + 24'd1;
            end else begin
                s1_cnt <= s1_cnt + 4'd1;
            end

            if (tick) begin
                if (byte_full) begin
                    slot_k <= '0;
                    pack_q <= '0;
                    data_q <= pack_next;
                end else begin
                    slot_k <= slot_k + n_pins;
                    pack_q <= pack_next;
                end
            end

            we_q <= byte_full;
            if (we_q && !end_hit) addr_q <= addr_q + 19'd1;
        end
    end

    assign sram.capture_active    = (state_q == ARMED) || (state_q == CAPTURE);
    assign sram.capture_done      = (state_q == DONE);
    assign sram.sram_addr_pat_cap = addr_q;
    assign sram.sram_data_pat_cap = data_q;
    assign sram.sram_we_pat_cap   = we_q;

endmodule

// File: tb/tb_pattern_capture.sv
// Self-checking bench for pattern_capture: directed scenarios plus randomized captures
// checked against a sample-history reference model.
module tb_pattern_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable;
    logic [23:0] end_a;
    logic [1:0]  nsel;
    logic [2:0]  ts;
    logic [3:0]  s1;
    logic [2:0]  tsel;
    logic        tpol;
    logic [7:0]  gpio;

    always #5 clk = ~clk;

    pattern_capture_if sram ();

    pattern_capture dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .cfg_enable_pat_cap           (enable),
        .cfg_end_address_pat_cap      (end_a),
        .cfg_num_gpio_sel_pat_cap     (nsel),
        .cfg_timestep_sel_pat_cap     (ts),
        .cfg_stage1_count_sel_pat_cap (s1),
        .cfg_trig_sel_pat_cap         (tsel),
        .cfg_trig_pol_pat_cap         (tpol),
        .gpio_pat_cap_in              (gpio),
        .sram                         (sram)
    );

    localparam int MAXC = 90000;

    typedef struct {
        int          at;
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [7:0] hist [MAXC];
    wr_t        wr_q [$];
    logic [7:0] script_q [$];
    int         cyc = 0;
    int         e0 = 0;
    int         last_entry = 0;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: record the pins seen at the rising edge, log writes and drive new pins mid-cycle.
    task automatic cycle();
        @(posedge clk);
        if (cyc < MAXC) hist[cyc] = gpio;
        cyc++;
        @(negedge clk);
        if (sram.sram_we_pat_cap)
            wr_q.push_back('{at: cyc - 1, addr: sram.sram_addr_pat_cap, data: sram.sram_data_pat_cap});
        if (script_q.size() > 0) gpio = script_q.pop_front();
        else                     gpio = 8'($urandom);
    endtask

    function automatic int period_of(input logic [3:0] s, input logic [2:0] t);
        int p;
        p = (s >= 4'd2) ? int'(s) : 1;
        for (int i = 0; i < int'(t); i++) p = p * 10;
        return (p < 2) ? 2 : p;
    endfunction

    // Edge index after which the block is in CAPTURE, given the edge that saw enable rise.
    function automatic int entry_of(input int start);
`ifdef PAT_CAP_TRIGGER_EN
        for (int x = start + 1; x < cyc; x++) begin
            if (x >= 3 && hist[x-2][tsel] == tpol && hist[x-3][tsel] != tpol) return x;
        end
        return -1;
`else
        return start + 1;
`endif
    endfunction

    // Byte b: tick j is sampled at edge ent + j*p and sees the pins from two edges earlier.
    function automatic logic [7:0] model_byte(input int ent, input int p, input int n, input int b);
        logic [7:0] r;
        logic [7:0] v;
        int         t;
        r = '0;
        t = 8 / n;
        for (int s = 0; s < t; s++) begin
            v = hist[ent + (b * t + s + 1) * p - 2];
            for (int i = 0; i < n; i++) r[7 - s * n - i] = v[i];
        end
        return r;
    endfunction

    task automatic run_capture(input logic [1:0] n_s, input logic [2:0] t_s, input logic [3:0] s_1,
                               input logic [23:0] e_a, input string nm);
        int n, t, p, nb, budget, waited, ent;
        nsel   = n_s;
        ts     = t_s;
        s1     = s_1;
        end_a  = e_a;
        enable = 1'b1;
        e0     = cyc;
        wr_q.delete();
        n      = 1 << n_s;
        t      = 8 / n;
        p      = period_of(s_1, t_s);
        nb     = int'(e_a[18:0]) + 1;
        budget = nb * t * p + 300;

        cycle();
        check({nm, "_armed_active"}, 32'(sram.capture_active), 32'd1);
        waited = 0;
        while (!sram.capture_done && waited < budget) begin
            cycle();
            waited++;
        end
        check({nm, "_done"}, 32'(sram.capture_done), 32'd1);
        check({nm, "_done_inactive"}, 32'(sram.capture_active), 32'd0);
        check({nm, "_nwrites"}, 32'(wr_q.size()), 32'(nb));

        ent = entry_of(e0);
        last_entry = ent;
        check({nm, "_trigger_found"}, 32'(ent >= 0), 32'd1);
        if (ent >= 0) begin
            for (int b = 0; b < nb && b < wr_q.size(); b++) begin
                check($sformatf("%s_addr%0d", nm, b), 32'(wr_q[b].addr), 32'(b));
                check($sformatf("%s_data%0d", nm, b), 32'(wr_q[b].data), 32'(model_byte(ent, p, n, b)));
                check($sformatf("%s_time%0d", nm, b), 32'(wr_q[b].at), 32'(ent + (b + 1) * t * p));
            end
        end

        enable = 1'b0;
        cycle();
        check({nm, "_clr_done"}, 32'(sram.capture_done), 32'd0);
        check({nm, "_clr_active"}, 32'(sram.capture_active), 32'd0);
        check({nm, "_clr_addr"}, 32'(sram.sram_addr_pat_cap), 32'd0);
        cycle();
    endtask

    initial begin
        enable = 1'b0;
        end_a  = '0;
        nsel   = '0;
        ts     = '0;
        s1     = '0;
        tsel   = 3'd3;
        tpol   = 1'b1;
        gpio   = '0;

        repeat (3) cycle();
        check("rst_active", 32'(sram.capture_active), 32'd0);
        check("rst_done", 32'(sram.capture_done), 32'd0);
        check("rst_we", 32'(sram.sram_we_pat_cap), 32'd0);
        check("rst_addr", 32'(sram.sram_addr_pat_cap), 32'd0);
        check("rst_data", 32'(sram.sram_data_pat_cap), 32'd0);

        // Enable already high when reset releases must not start a capture.
        enable = 1'b1;
        cycle();
        rst_n = 1'b1;
        repeat (6) cycle();
        check("no_start_after_reset", 32'(sram.capture_active), 32'd0);
        enable = 1'b0;
        repeat (2) cycle();

        // N=8, fastest tick: three bytes A5, 3C, FF two clocks apart.
        script_q = '{8'h00, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'hFF, 8'hFF};
        cycle();
        run_capture(2'd3, 3'd0, 4'd0, 24'd2, "r031");
`ifndef PAT_CAP_TRIGGER_EN
        if (wr_q.size() >= 3) begin
            check("r031_d0", 32'(wr_q[0].data), 32'hA5);
            check("r031_d1", 32'(wr_q[1].data), 32'h3C);
            check("r031_d2", 32'(wr_q[2].data), 32'hFF);
            check("r031_gap", 32'(wr_q[1].at - wr_q[0].at), 32'd2);
        end
`endif

        // N=1, single byte from pin0 sequence 1,0,1,1,0,0,1,0.
        script_q.delete();
        script_q.push_back(8'h00);
        foreach (script_q[i]) ;
        begin
            logic [7:0] seq;
            seq = 8'b1011_0010;
            for (int j = 7; j >= 0; j--) begin
                script_q.push_back({7'd0, seq[j]});
                script_q.push_back({7'd0, seq[j]});
            end
        end
        cycle();
        run_capture(2'd0, 3'd0, 4'd0, 24'd0, "r032");
`ifndef PAT_CAP_TRIGGER_EN
        if (wr_q.size() >= 1) check("r032_byte", 32'(wr_q[0].data), 32'hB2);
`endif

        // N=2, 12 x 10 = 120-clock ticks, one byte after four ticks.
        run_capture(2'd1, 3'd1, 4'd12, 24'd0, "r033");
`ifndef PAT_CAP_TRIGGER_EN
        if (wr_q.size() >= 1) check("r033_latency", 32'(wr_q[0].at - e0), 32'd481);
`endif

        // Upper end-address bits are ignored: 0xF80001 behaves as end address 1.
        run_capture(2'd3, 3'd0, 4'd3, 24'hF80001, "hiaddr");

        // Abort after five of eight N=1 samples.
        nsel   = 2'd0;
        ts     = 3'd0;
        s1     = 4'd0;
        end_a  = 24'd0;
        enable = 1'b1;
        e0     = cyc;
        wr_q.delete();
        while (cyc <= e0 + 11) cycle();
        enable = 1'b0;
        cycle();
        check("abort_active", 32'(sram.capture_active), 32'd0);
        check("abort_done", 32'(sram.capture_done), 32'd0);
        check("abort_we", 32'(sram.sram_we_pat_cap), 32'd0);
        check("abort_addr", 32'(sram.sram_addr_pat_cap), 32'd0);
        check("abort_data", 32'(sram.sram_data_pat_cap), 32'd0);
        check("abort_nwrites", 32'(wr_q.size()), 32'd0);
        cycle();
        run_capture(2'd0, 3'd0, 4'd0, 24'd1, "restart");

        // Reset pulse in the middle of a capture.
        nsel   = 2'd3;
        ts     = 3'd0;
        s1     = 4'd0;
        end_a  = 24'd5;
        enable = 1'b1;
        repeat (6) cycle();
        rst_n = 1'b0;
        #1;
        check("rstmid_active", 32'(sram.capture_active), 32'd0);
        check("rstmid_done", 32'(sram.capture_done), 32'd0);
        check("rstmid_we", 32'(sram.sram_we_pat_cap), 32'd0);
        check("rstmid_addr", 32'(sram.sram_addr_pat_cap), 32'd0);
        check("rstmid_data", 32'(sram.sram_data_pat_cap), 32'd0);
        cycle();
        rst_n = 1'b1;
        wr_q.delete();
        repeat (30) cycle();
        check("rstmid_no_restart", 32'(sram.capture_active), 32'd0);
        check("rstmid_no_writes", 32'(wr_q.size()), 32'd0);
        enable = 1'b0;
        repeat (2) cycle();

`ifdef PAT_CAP_TRIGGER_EN
        // Pin 3 low for 50 clocks after enable, then high: capture starts on that rising edge.
        script_q.delete();
        for (int i = 0; i < 52; i++) script_q.push_back(8'($urandom) & 8'hF7);
        for (int i = 0; i < 40; i++) script_q.push_back(8'($urandom) | 8'h08);
        repeat (3) cycle();
        run_capture(2'd3, 3'd0, 4'd0, 24'd1, "r035");
        check("r035_entry", 32'(last_entry - e0), 32'd52);
        if (wr_q.size() >= 1) check("r035_first_write", 32'(wr_q[0].at - e0), 32'd54);
`endif

        for (int r = 0; r < 8; r++) begin
            run_capture(2'($urandom_range(3, 0)), 3'($urandom_range(1, 0)), 4'($urandom_range(5, 0)),
                        24'($urandom_range(3, 0)), $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_capture.md
PATTERN_CAPTURE -- requirements
Module: pattern_capture

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cfg_enable_pat_cap  input  1  rising edge arms/starts capture; low aborts and clears.
REQ-004 cfg_end_address_pat_cap  input  24  last SRAM byte address written (inclusive); only [18:0] used.
REQ-005 cfg_num_gpio_sel_pat_cap  input  2  pins sampled per tick: 00=1, 01=2, 10=4, 11=8.
REQ-006 cfg_timestep_sel_pat_cap  input  3  tick multiplier 10^n.
REQ-007 cfg_stage1_count_sel_pat_cap  input  4  clock-to-base-10 prescaler.
REQ-008 cfg_trig_sel_pat_cap  input  3  trigger pin index (macro-gated).
REQ-009 cfg_trig_pol_pat_cap  input  1  1=rising, 0=falling trigger edge (macro-gated).
REQ-010 gpio_pat_cap_in  input  8  asynchronous pins to capture.
REQ-011 capture_active  output  1  high while block owns SRAM.
REQ-012 capture_done  output  1  high after last byte written, until enable low.
REQ-013 sram_addr_pat_cap  output  19  SRAM write address.
REQ-014 sram_data_pat_cap  output  8  SRAM write data.
REQ-015 sram_we_pat_cap  output  1  one-cycle write strobe.

Function
REQ-016 gpio_pat_cap_in SHALL pass a 2-flop synchronizer per bit; all sampling and trigger detection use synchronized values.
REQ-017 FSM states IDLE, ARMED, CAPTURE, DONE; IDLE->ARMED on enable rising edge; ARMED->CAPTURE on trigger; CAPTURE->DONE the cycle after final write; DONE->IDLE when enable low.
REQ-018 Enable low in any state SHALL, next cycle, force IDLE, clear counters, address, partial byte, capture_active, capture_done, sram_we; partial byte never written.
REQ-019 Prescaler period P1 = cfg_stage1_count_sel when >=2, else 1; tick period = P1 x 10^n clocks, minimum 2 clocks.
REQ-020 Tick counters SHALL clear on CAPTURE entry; first sample on first tick, one full period after entry.
REQ-021 Packing MSB-first, slot index k starts 0 and advances by N (1,2,4,8) per tick: byte bit (7-k-i) <= pin i, i=0..N-1 (exact inverse of the pattern generator bit order).
REQ-022 Byte complete when k reaches 8-N; next cycle sram_we=1 for one cycle with sram_data and sram_addr stable that cycle; k resets to 0.
REQ-023 Address SHALL start 0, increment the cycle after each write except the write at end address.
REQ-024 Write at end address -> next cycle capture_active=0, capture_done=1, state DONE; no further writes.
REQ-025 capture_active high in ARMED, CAPTURE; low in IDLE, DONE.
REQ-026 End address 0 captures exactly one byte; cfg changes mid-capture are unsupported (undefined).

Reset
REQ-027 rst_n low asynchronously sets state IDLE and every output, counter, synchronizer flop and shift register to 0.
REQ-028 Reset deassertion with enable already high SHALL NOT start capture; a fresh rising edge is required.

Configuration
REQ-029 Macro PAT_CAP_TRIGGER_EN defined: ARMED waits for selected-pin edge of selected polarity (synchronized value vs previous cycle); trigger ports used.
REQ-030 PAT_CAP_TRIGGER_EN undefined: ARMED lasts exactly one cycle then enters CAPTURE; trigger ports ignored (may be unconnected).

Verification
REQ-031 N=8, timestep 0, stage1 0, end 2, pins 0xA5,0x3C,0xFF per tick -> three writes addr 0,1,2 data A5,3C,FF, writes 2 clocks apart, then done=1.
REQ-032 N=1, end 0, pin0 sequence 1,0,1,1,0,0,1,0 -> single write addr 0 data 0xB2.
REQ-033 N=2, stage1 12, timestep 1, end 0 -> ticks every 120 clocks, one write after 4 ticks.
REQ-034 Enable dropped after 5 of 8 samples (N=1) -> no write, all outputs 0 next cycle; re-enable restarts at addr 0.
REQ-035 PAT_CAP_TRIGGER_EN, trig pin 3 rising: pin3 held 0 for 50 clocks then 1 -> no write/tick before edge; first tick one period after CAPTURE entry.
REQ-036 rst_n pulsed mid-capture -> all outputs 0 immediately; no capture until new enable edge.
